vec256_exec: RTL
================

Name: vec256_exec

Overview:
- Execute/write-back stage directly downstream of the 32x256-bit register file.
- Consumes the register file's two combinational read outputs (R, S) as operands and performs a lane-wise vector operation.
- Drives the register file's write port (W_En, W_Addr, WR) with the result.
- Includes a one-entry write-back bypass so a dependent op can issue in the write-back cycle.

Parameters:
- DATA_W, 256: operand/result width; must equal register width.
- LANE_W, 16: lane width for arithmetic, shift and multiply ops.
- MUL_LPC, 4: multiply lanes computed per cycle; MUL_CYC = (DATA_W/LANE_W)/MUL_LPC = 4.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  upstream presents an op.
- issue_ready  out  1  block can accept an op this cycle.
- opcode  in  4  operation select.
- dest  in  5  destination register address.
- R_Addr  in  5  source-R address, used for bypass compare.
- S_Addr  in  5  source-S address, used for bypass compare.
- R  in  DATA_W  operand R from the register file.
- S  in  DATA_W  operand S from the register file.
- W_En  out  1  register-file write enable.
- W_Addr  out  5  register-file write address.
- WR  out  DATA_W  write data.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (async assert, sync release): state=IDLE; W_En=0; W_Addr=0; WR=0; illegal_op=0; operand/result registers=0; issue_ready=1.
- Handshake: an op is accepted on a rising edge with issue_valid && issue_ready. At that edge opcode, dest and operands are latched.
- issue_ready=1 in IDLE and WB, 0 in EXEC and MUL.
- Operand bypass at accept: if state==WB and R_Addr==W_Addr, latch WR instead of R. Apply the same rule to S_Addr/S. Both may bypass at once.
- Opcodes, all lane-wise on DATA_W/LANE_W lanes, unsigned, with wrap-around and no carry across lanes:
  - 0 ADD; 1 SUB (R-S mod 2^LANE_W); 2 AND; 3 OR; 4 XOR.
  - 5 SHL: R lane << S lane[3:0]. 6 SHR: logical R lane >> S lane[3:0].
  - 7 MUL: low LANE_W bits of R lane*S lane.
  - 8 MOV: result = R.
  - 9-15: illegal.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: on accept, opcode 7 -> MUL with cnt=0; opcodes 0-6 and 8 -> EXEC; illegal -> IDLE with illegal_op=1 for one cycle and no write.
  - EXEC: result registered into WR at next edge, W_Addr=dest, W_En=1 -> WB. Latency is accept edge k to W_En high during cycle k+1..k+2.
  - MUL: each edge computes lanes cnt*MUL_LPC .. cnt*MUL_LPC+MUL_LPC-1 into the result register, then cnt++. After cnt==MUL_CYC-1: W_En=1, state WB. W_En is high during cycle k+4..k+5.
  - WB: W_En=1 for exactly one cycle, and the register file writes at the edge ending WB. If an accept occurs in WB, next state follows the IDLE accept rules; otherwise next state is IDLE. W_En drops unless the new op's own WB follows.
- Back-to-back simple ops sustain one result per 2 cycles.
- W_Addr and WR hold their last values while W_En=0. The register file ignores them.
- A dest equal to a source is legal; the bypass supplies the pending value.
- Reset asserted mid-EXEC, MUL or WB: the op is aborted, no write occurs, and all outputs go immediately to reset values.
- issue_valid while issue_ready=0: ignored, not queued. Upstream holds it.

Test Plan:
- Reset then ADD with dest=3, R lanes all 0xFFFF, S lanes all 0x0002 -> one cycle after accept: W_En=1 for 1 cycle, W_Addr=3, every WR lane=0x0001 (wrap).
- MUL with R lanes=0x0100, S lanes=0x0300, dest=7 -> issue_ready=0 for 4 cycles, then W_En=1 with every WR lane=0x0000. Repeat with 0x0003*0x0005 -> every lane=0x000F.
- ADD to r5 immediately followed in the WB cycle by XOR with R_Addr=5 and stale R=0 -> XOR uses the bypassed WR value; the second write is correct.
- SHR with R lanes=0x8000, S lanes=0x000F -> every lane=0x0001. SHL with S lane[3:0]=0 -> WR=R.
- opcode=12 -> illegal_op pulses 1 cycle, W_En stays 0, issue_ready stays 1.
- Pull reset_n low during cycle 2 of MUL -> W_En never asserts, outputs go to 0 asynchronously, FSM=IDLE after release.

Source files
------------

// File: rtl/vec256_exec.sv
// Execute/write-back stage for the 32x256-bit register file: lane-wise vector ALU,
// a multi-cycle lane multiplier and a one-entry write-back bypass.
module vec256_exec #(
    parameter int DATA_W  = 256,
    parameter int LANE_W  = 16,
    parameter int MUL_LPC = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        opcode,
    input  logic [4:0]        dest,
    input  logic [4:0]        R_Addr,
    input  logic [4:0]        S_Addr,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] S,
    output logic              W_En,
    output logic [4:0]        W_Addr,
    output logic [DATA_W-1:0] WR,
    output logic              illegal_op,
    output logic [1:0]        fsm_state
);

    localparam int LANES   = DATA_W / LANE_W;
    localparam int MUL_CYC = LANES / MUL_LPC;
    localparam int CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam int SH_W    = $clog2(LANE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [3:0]        op_r;
    logic [4:0]        dest_r;
    logic [DATA_W-1:0] a_r, b_r;
    logic [DATA_W-1:0] mul_acc, mul_next, alu_res;
    logic [CNT_W-1:0]  cnt;
    logic [LANE_W-1:0] alu_a, alu_b, alu_lane;
    logic [LANE_W-1:0] mul_a, mul_b, mul_lane;
    int                mul_idx;
    logic              accept, op_legal, mul_last, byp_r, byp_s;

    // Handshake: an op transfers on a rising edge where issue_valid && issue_ready;
    // issue_ready depends only on state, and a held issue_valid while busy is ignored.
    assign issue_ready = (state == IDLE) || (state == WB);
    assign accept      = issue_valid && issue_ready;
    assign op_legal    = opcode <= 4'd8;
    assign mul_last    = cnt == CNT_W'(MUL_CYC - 1);
    assign W_En        = state == WB;
    assign fsm_state   = state;

    // The register file has not yet committed the WB result, so forward it.
    assign byp_r = (state == WB) && (R_Addr == W_Addr);
    assign byp_s = (state == WB) && (S_Addr == W_Addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, WB: begin
                state_next = IDLE;
                if (accept && op_legal) begin
                    state_next = (opcode == 4'd7) ? MUL : EXEC;
                end
            end
            EXEC:    state_next = WB;
            MUL:     if (mul_last) state_next = WB;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_res  = '0;
        alu_a    = '0;
        alu_b    = '0;
        alu_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            alu_a = a_r[i*LANE_W +: LANE_W];
            alu_b = b_r[i*LANE_W +: LANE_W];
            case (op_r)
                4'd0:    alu_lane = alu_a + alu_b;
                4'd1:    alu_lane = alu_a - alu_b;
                4'd2:    alu_lane = alu_a & alu_b;
                4'd3:    alu_lane = alu_a | alu_b;
                4'd4:    alu_lane = alu_a ^ alu_b;
                4'd5:    alu_lane = alu_a << alu_b[SH_W-1:0];
                4'd6:    alu_lane = alu_a >> alu_b[SH_W-1:0];
                4'd8:    alu_lane = alu_a;
                default: alu_lane = '0;
            endcase
            alu_res[i*LANE_W +: LANE_W] = alu_lane;
        end
    end

    // MUL_LPC multipliers are shared across the op; cnt selects which lane group they serve.
    always_comb begin
        mul_next = mul_acc;
        mul_idx  = 0;
        mul_a    = '0;
        mul_b    = '0;
        mul_lane = '0;
        for (int j = 0; j < MUL_LPC; j++) begin
            mul_idx  = int'(cnt) * MUL_LPC + j;
            mul_a    = a_r[mul_idx*LANE_W +: LANE_W];
            mul_b    = b_r[mul_idx*LANE_W +: LANE_W];
            mul_lane = mul_a * mul_b;
            mul_next[mul_idx*LANE_W +: LANE_W] = mul_lane;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            W_Addr     <= '0;
            WR         <= '0;
            illegal_op <= 1'b0;
            op_r       <= '0;
            dest_r     <= '0;
            a_r        <= '0;
            b_r        <= '0;
            mul_acc    <= '0;
            cnt        <= '0;
        end else begin
            illegal_op <= accept && !op_legal;
            if (accept && op_legal) begin
                op_r   <= opcode;
                dest_r <= dest;
                a_r    <= byp_r ? WR : R;
                b_r    <= byp_s ? WR : S;
                cnt    <= '0;
            end
            if (state == EXEC) begin
                WR     <= alu_res;
                W_Addr <= dest_r;
            end
            // Partial products stay in mul_acc so WR keeps the last written value.
            if (state == MUL) begin
                mul_acc <= mul_next;
                cnt     <= cnt + CNT_W'(1);
                if (mul_last) begin
                    WR     <= mul_next;
                    W_Addr <= dest_r;
                end
            end
        end
    end

endmodule
